// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - Avalon-MM sequencer that retunes the video PLL between two fractional profiles
module pll_reconfig_ctrl #(
    parameter logic [31:0] M_WORD      = 32'h0000_0404,
    parameter logic [31:0] PROF0_K     = 32'd425936216,
    parameter logic [31:0] PROF1_K     = 32'd0,
    parameter logic [19:0] TIMEOUT     = 20'hFFFFF,
    parameter int unsigned LOCK_STABLE = 16
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic        req,
    input  logic        profile_sel,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        core_reset_n,
    output logic        active_profile,
    output logic        active_valid,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);
    typedef enum logic [2:0] {
        IDLE, WR_MODE, WR_M, WR_K, WR_START, POLL, WAIT_LOCK, FAIL
    } state_t;

    state_t      state;
    state_t      wr_next;
    logic        target;
    logic [19:0] tmo_cnt;
    logic [15:0] lock_cnt;
    logic [1:0]  lock_sync;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        timed;
    logic        tmo_hit;

    assign timed   = (state == WR_START) || (state == POLL) || (state == WAIT_LOCK);
    assign tmo_hit = timed && ((tmo_cnt + 20'd1) == TIMEOUT);

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) lock_sync <= 2'b00;
        else          lock_sync <= {lock_sync[0], pll_locked};
    end

    always_comb begin
        wr_addr = 6'h00;
        wr_data = 32'd1;
        wr_next = WR_M;
        case (state)
            WR_M:     begin wr_addr = 6'h04; wr_data = M_WORD;  wr_next = WR_K;     end
            WR_K:     begin wr_addr = 6'h07; wr_data = target ? PROF1_K : PROF0_K; wr_next = WR_START; end
            WR_START: begin wr_addr = 6'h02; wr_data = 32'd0;   wr_next = POLL;     end
            default:  ;
        endcase
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            target         <= 1'b0;
            tmo_cnt        <= '0;
            lock_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            core_reset_n   <= 1'b0;
            active_profile <= 1'b0;
            active_valid   <= 1'b0;
            mgmt_address   <= '0;
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            mgmt_writedata <= '0;
        end else begin
            done <= 1'b0;
            if (timed) tmo_cnt <= tmo_cnt + 20'd1;
            case (state)
                IDLE: begin
                    core_reset_n <= 1'b1;
                    if (req) begin
                        target <= profile_sel;
                        error  <= 1'b0;
                        if (active_valid && (profile_sel == active_profile)) begin
                            done <= 1'b1;
                        end else begin
                            state        <= WR_MODE;
                            busy         <= 1'b1;
                            core_reset_n <= 1'b0;
                        end
                    end
                end
                // Each write starts from a strobe-low cycle, so writes are never back-to-back.
                WR_MODE, WR_M, WR_K, WR_START: begin
                    if (!mgmt_write) begin
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= wr_addr;
                        mgmt_writedata <= wr_data;
                    end else if (!mgmt_waitrequest) begin
                        mgmt_write <= 1'b0;
                        state      <= wr_next;
                        if (wr_next == WR_START) tmo_cnt <= '0;
                    end
                end
                POLL: begin
                    if (!mgmt_read) begin
                        mgmt_read    <= 1'b1;
                        mgmt_address <= 6'h01;
                    end else if (!mgmt_waitrequest) begin
                        mgmt_read <= 1'b0;
                        if (mgmt_readdata[0]) begin
                            state    <= WAIT_LOCK;
                            lock_cnt <= '0;
                        end
                    end
                end
                WAIT_LOCK: begin
                    if (!lock_sync[1]) begin
                        lock_cnt <= '0;
                    end else if ((lock_cnt + 16'd1) == 16'(LOCK_STABLE)) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        core_reset_n   <= 1'b1;
                        active_profile <= target;
                        active_valid   <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + 16'd1;
                    end
                end
                FAIL: begin
                    if (req) begin
                        target <= profile_sel;
                        error  <= 1'b0;
                        state  <= WR_MODE;
                        busy   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Timeout wins over whatever the state decided this cycle.
            if (tmo_hit) begin
                state        <= FAIL;
                busy         <= 1'b0;
                done         <= 1'b0;
                error        <= 1'b1;
                active_valid <= 1'b0;
                core_reset_n <= 1'b0;
                mgmt_write   <= 1'b0;
                mgmt_read    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - directed bench for pll_reconfig_ctrl with a scripted Avalon slave
module tb_pll_reconfig_ctrl;
    localparam logic [31:0] M_W = 32'h0000_0404;
    localparam logic [31:0] K0  = 32'd425936216;
    localparam logic [31:0] K1  = 32'h0ABC_DEF1;

    logic        clk_74a;
    logic        reset_n;
    logic        req;
    logic        profile_sel;
    logic        busy;
    logic        done;
    logic        error;
    logic        core_reset_n;
    logic        active_profile;
    logic        active_valid;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    int n_vec = 0;
    int n_miss = 0;
    int cyc, rd_cnt, rd_last, bad_gap, rd_bad_addr, both_cnt, crn_bad, wr_high, m_hold;
    int stall_left, zeros_left, done_cnt, done_cyc, rdok_cyc, err_cyc, kacc_cyc;
    logic [5:0]  stall_addr;
    bit          k_seen;
    logic [5:0]  wa_q[$];
    logic [31:0] wd_q[$];

    pll_reconfig_ctrl #(
        .M_WORD(M_W), .PROF0_K(K0), .PROF1_K(K1), .TIMEOUT(20'd100), .LOCK_STABLE(16)
    ) dut (
        .clk_74a(clk_74a), .reset_n(reset_n), .req(req), .profile_sel(profile_sel),
        .busy(busy), .done(done), .error(error), .core_reset_n(core_reset_n),
        .active_profile(active_profile), .active_valid(active_valid),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
    );

    initial begin
        clk_74a = 1'b0;
        forever #5 clk_74a = ~clk_74a;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_74a);
            #2;
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        rd_cnt = 0; rd_last = -1; bad_gap = 0; wr_high = 0; m_hold = 0;
        done_cnt = 0; done_cyc = -1; rdok_cyc = -1; err_cyc = -1; kacc_cyc = -1;
        stall_left = 0; zeros_left = 0; k_seen = 1'b0;
    endtask

    // Avalon slave: decides waitrequest/readdata mid-cycle and logs every accepted transfer.
    task automatic bus_model();
        forever begin
            @(negedge clk_74a);
            cyc++;
            mgmt_waitrequest = 1'b0;
            mgmt_readdata    = (zeros_left > 0) ? 32'hFFFF_FFFE : 32'h0000_0001;
            if (mgmt_write && mgmt_read) both_cnt++;
            if (busy && core_reset_n) crn_bad++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (error && err_cyc < 0) err_cyc = cyc;
            if (mgmt_write) begin
                wr_high++;
                if (mgmt_address == 6'h07) k_seen = 1'b1;
                if (mgmt_address == 6'h04 && mgmt_writedata == M_W) m_hold++;
                if (mgmt_address == stall_addr && stall_left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    wa_q.push_back(mgmt_address);
                    wd_q.push_back(mgmt_writedata);
                    if (mgmt_address == 6'h07) kacc_cyc = cyc;
                end
            end
            if (mgmt_read) begin
                rd_cnt++;
                if (mgmt_address != 6'h01) rd_bad_addr++;
                if (rd_last >= 0 && (cyc - rd_last) != 2) bad_gap++;
                rd_last = cyc;
                if (zeros_left > 0) zeros_left--;
                else rdok_cyc = cyc;
            end
        end
    endtask

    task automatic issue_req(input logic p);
        profile_sel = p;
        req = 1'b1;
        step(1);
        req = 1'b0;
        profile_sel = ~p;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin step(1); n++; end
        chk(tag, (done_cnt > 0) ? 1 : 0, 1);
    endtask

    task automatic wait_rdok(input string tag, input int budget);
        int n = 0;
        while (rdok_cyc < 0 && n < budget) begin step(1); n++; end
        chk(tag, (rdok_cyc >= 0) ? 1 : 0, 1);
    endtask

    task automatic chk_writes(input string tag, input logic [31:0] kval);
        logic [5:0]  ea[4];
        logic [31:0] ed[4];
        ea = '{6'h00, 6'h04, 6'h07, 6'h02};
        ed = '{32'd1, M_W, kval, 32'd0};
        chk({tag, "_nwr"}, wa_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_addr"}, (i < wa_q.size()) ? wa_q[i] : 6'h3F, ea[i]);
            chk({tag, "_data"}, (i < wd_q.size()) ? wd_q[i] : 32'hDEAD_BEEF, ed[i]);
        end
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; profile_sel = 1'b0; pll_locked = 1'b1;
        mgmt_waitrequest = 1'b0; mgmt_readdata = '0;
        cyc = 0; both_cnt = 0; crn_bad = 0; rd_bad_addr = 0; stall_addr = 6'h3F;
        clear_log();
        fork bus_model(); join_none

        step(3);
        chk("rst_ctrl", {busy, done, error, core_reset_n, active_valid, active_profile}, 0);
        chk("rst_bus", {mgmt_write, mgmt_read, mgmt_address}, 0);
        reset_n = 1'b1;
        chk("crn_held", core_reset_n, 0);
        step(1);
        chk("crn_release", core_reset_n, 1);

        // Profile 1 clean run; a req during the sequence must be ignored.
        clear_log();
        issue_req(1'b1);
        chk("p1_busy", {busy, core_reset_n}, 2'b10);
        wait_rdok("p1_read_ok", 100);
        issue_req(1'b0);
        wait_done("p1_done", 100);
        chk_writes("p1", K1);
        chk("p1_reads", rd_cnt, 1);
        chk("p1_lock_lat", done_cyc - rdok_cyc, 17);
        chk("p1_active", {active_valid, active_profile, core_reset_n, busy, error}, 5'b11100);
        step(2);
        chk("p1_done_pulse", done_cnt, 1);

        // Same profile again: done next cycle, no bus traffic.
        clear_log();
        issue_req(1'b1);
        chk("same_done", done, 1);
        step(4);
        chk("same_nobus", wr_high + rd_cnt, 0);
        chk("same_idle", {busy, core_reset_n}, 2'b01);

        // Stalled M write, three not-ready polls, lock glitch at count 10.
        clear_log();
        stall_addr = 6'h04; stall_left = 5; zeros_left = 3;
        issue_req(1'b0);
        wait_rdok("p0_read_ok", 200);
        step(8);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        wait_done("p0_done", 100);
        chk_writes("p0", K0);
        chk("p0_m_hold", m_hold, 6);
        chk("p0_wr_cycles", wr_high, 9);
        chk("p0_reads", rd_cnt, 4);
        chk("p0_read_gap", bad_gap, 0);
        chk("p0_lock_restart", done_cyc - rdok_cyc, 28);
        chk("p0_active", {active_valid, active_profile}, 2'b10);

        // Timeout with lock stuck low, then recovery.
        clear_log();
        pll_locked = 1'b0;
        issue_req(1'b1);
        begin
            int n = 0;
            while (err_cyc < 0 && n < 300) begin step(1); n++; end
        end
        chk("tmo_seen", (err_cyc >= 0) ? 1 : 0, 1);
        chk("tmo_latency", err_cyc - kacc_cyc, 101);
        step(3);
        chk("tmo_state", {error, core_reset_n, busy, active_valid, mgmt_write, mgmt_read}, 6'b100000);
        chk("tmo_nodone", done_cnt, 0);
        clear_log();
        pll_locked = 1'b1;
        issue_req(1'b1);
        chk("tmo_clear", {error, busy}, 2'b01);
        wait_done("tmo_retry_done", 200);
        chk_writes("retry", K1);
        chk("retry_active", {active_valid, active_profile, error}, 3'b110);

        // Reset in the middle of the K write.
        clear_log();
        stall_addr = 6'h07; stall_left = 3;
        issue_req(1'b0);
        begin
            int n = 0;
            while (!k_seen && n < 100) begin step(1); n++; end
        end
        chk("mid_k_pending", {mgmt_write, mgmt_address}, {1'b1, 6'h07});
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bus", {mgmt_write, mgmt_read}, 0);
        chk("mid_rst_ctrl", {busy, active_valid, core_reset_n, done}, 0);
        step(2);
        reset_n = 1'b1;
        step(2);
        clear_log();
        issue_req(1'b0);
        chk("post_rst_nodone", done, 0);
        wait_done("post_rst_done", 200);
        chk_writes("post_rst", K0);
        chk("post_rst_active", {active_valid, active_profile}, 2'b10);

        chk("no_dual_strobe", both_cnt, 0);
        chk("crn_low_busy", crn_bad, 0);
        chk("read_addr", rd_bad_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
